// File: rtl/sram_like_pkg.sv
// sram_like_pkg: size encodings, response entry type and lane-mask decode shared by the sram_like slave.
package sram_like_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam int TW = 3;

    typedef struct packed {
        logic          wr;
        logic [31:0]   rdata;
        logic [TW-1:0] timer;
    } resp_t;

    // Byte-lane write mask; sizes 2 and 3 both mean a full word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return size >= SZ_WORD ? 4'b1111 : size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    endfunction
endpackage

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo: in-order response queue whose entries count down their release timers in place.
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  resp_t push_ent,
    input  logic  pop,
    output logic  head_vld,
    output resp_t head
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    resp_t [DEPTH-1:0] ent_q, ent_d;
    logic  [DEPTH-1:0] vld_q, vld_d;
    logic  [PW-1:0]    rd_q, rd_d, wr_q, wr_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        ent_d = ent_q;
        vld_d = vld_q;
        rd_d = rd_q;
        wr_d = wr_q;
        for (int i = 0; i < DEPTH; i++)
            if (ent_q[i].timer != '0) ent_d[i].timer = ent_q[i].timer - TW'(1);
        if (pop) begin
            vld_d[rd_q] = 1'b0;
            rd_d = nxt(rd_q);
        end
        if (push) begin
            ent_d[wr_q] = push_ent;
            vld_d[wr_q] = 1'b1;
            wr_d = nxt(wr_q);
        end
        head_vld = vld_q[rd_q];
        head = ent_q[rd_q];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ent_q <= '0;
            vld_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
        end else begin
            ent_q <= ent_d;
            vld_q <= vld_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
        end
endmodule

// File: rtl/sram_like_slave.sv
// sram_like_slave: sram-like bus slave fronting a synchronous SRAM with bounded outstanding, in-order responses.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int AW    = 16,
    parameter int LAT   = 0,
    parameter int OUTST = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          addr_ok,
    output logic          data_ok,
    output logic [31:0]   rdata,
    output logic          sram_en,
    output logic [3:0]    sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);
    logic [2:0] cnt_q, cnt_d;
    logic       cap_vld_q, cap_vld_d, cap_wr_q, cap_wr_d;
    logic       head_vld;
    resp_t      head, push_ent;
    logic       unused_ok;

    assign sram_addr = addr[AW+1:2];
    assign sram_wdata = wdata;
    assign unused_ok = ^{addr[31:AW+2], head.wr};

    // cnt covers capture stage plus queued entries, so the queue can never overflow.
    always_comb begin
        addr_ok = !reset && req && cnt_q < 3'(OUTST);
        sram_en = req && addr_ok;
        sram_wen = sram_en && wr ? lane_mask(size, addr[1:0]) : 4'b0000;
        data_ok = head_vld && head.timer == '0;
        rdata = data_ok ? head.rdata : 32'h0;
        cap_vld_d = sram_en;
        cap_wr_d = wr;
        push_ent = '{wr: cap_wr_q, rdata: cap_wr_q ? 32'h0 : sram_rdata, timer: TW'(LAT)};
        cnt_d = sram_en && !data_ok ? cnt_q + 3'd1 : !sram_en && data_ok ? cnt_q - 3'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt_q <= '0;
            cap_vld_q <= 1'b0;
            cap_wr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cap_vld_q <= cap_vld_d;
            cap_wr_q <= cap_wr_d;
        end

    sram_like_resp_fifo #(.DEPTH(OUTST)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cap_vld_q),
        .push_ent(push_ent),
        .pop     (data_ok),
        .head_vld(head_vld),
        .head    (head)
    );
endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave: two slave instances (LAT0/OUTST4, LAT3/OUTST2) with SRAM models and a response scoreboard.
module tb_sram_like_slave;
    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       reset, req, wr, addr_ok, data_ok, sram_en;
    logic [1:0][1:0]  size;
    logic [1:0][31:0] addr, wdata, rdata, sram_wdata;
    logic [1:0][3:0]  sram_wen;
    logic [1:0][7:0]  sram_addr;

    exp_t sb [2][$];
    int cyc = 0, compared = 0, mismatched = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0]  mem [256];
        logic [255:0] hit = '0;
        logic [31:0]  rd_q;

        // Unwritten words read back as C0DE_00xx with xx = word address.
        function automatic logic [31:0] word(input logic [7:0] a);
            return hit[a] ? mem[a] : 32'hC0DE_0000 | {24'h0, a};
        endfunction

        always @(posedge clk)
            if (sram_en[g]) begin
                rd_q <= word(sram_addr[g]);
                if (sram_wen[g] != 4'h0) begin
                    mem[sram_addr[g]] <= merge(word(sram_addr[g]), sram_wdata[g], sram_wen[g]);
                    hit[sram_addr[g]] <= 1'b1;
                end
            end

        sram_like_slave #(.AW(8), .LAT(g == 0 ? 0 : 3), .OUTST(g == 0 ? 4 : 2)) dut (
            .clk       (clk),
            .reset     (reset[g]),
            .req       (req[g]),
            .wr        (wr[g]),
            .size      (size[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .addr_ok   (addr_ok[g]),
            .data_ok   (data_ok[g]),
            .rdata     (rdata[g]),
            .sram_en   (sram_en[g]),
            .sram_wen  (sram_wen[g]),
            .sram_addr (sram_addr[g]),
            .sram_wdata(sram_wdata[g]),
            .sram_rdata(rd_q)
        );

        initial forever begin
            @(negedge clk);
            if (data_ok[g]) begin
                if (sb[g].size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL dut%0d unexpected data_ok: got completion rdata %h at cycle %0d, required none", g, rdata[g], cyc);
                end else begin
                    exp_t e;
                    e = sb[g].pop_front();
                    check($sformatf("dut%0d rdata", g), rdata[g], e.d);
                    check($sformatf("dut%0d data_ok cycle", g), cyc, e.due);
                end
            end
        end
    end

    task automatic issue(input int g, input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] xd, input logic [3:0] xw, output int t);
        int n;
        n = 0;
        t = -1;
        req[g] = 1'b1;
        wr[g] = w;
        size[g] = sz;
        addr[g] = a;
        wdata[g] = wd;
        @(negedge clk);
        while (!addr_ok[g] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!addr_ok[g]) begin
            compared++;
            mismatched++;
            $display("FAIL dut%0d accept timeout addr %h: addr_ok got 0, required 1", g, a);
        end else begin
            t = cyc;
            check($sformatf("dut%0d sram_en", g), sram_en[g], 1);
            check($sformatf("dut%0d sram_wen @%h", g, a), sram_wen[g], xw);
            check($sformatf("dut%0d sram_addr", g), sram_addr[g], a[9:2]);
            check($sformatf("dut%0d sram_wdata", g), sram_wdata[g], wd);
            sb[g].push_back(exp_t'{w ? 32'h0 : xd, cyc + 2 + (g == 0 ? 0 : 3)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int g, input int n);
        req[g] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, t1, t2, r, n;
        int bp [6];
        int rel [6] = '{0, 1, 6, 7, 12, 13};
        reset = 2'b11;
        req = 2'b11;
        wr = 2'b11;
        size = '{2'd2, 2'd2};
        addr = '{32'h40, 32'h40};
        wdata = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("dut%0d reset addr_ok", g), addr_ok[g], 0);
            check($sformatf("dut%0d reset sram_en", g), sram_en[g], 0);
            check($sformatf("dut%0d reset sram_wen", g), sram_wen[g], 0);
            check($sformatf("dut%0d reset data_ok", g), data_ok[g], 0);
            check($sformatf("dut%0d reset rdata", g), rdata[g], 0);
        end
        @(posedge clk);
        #1;
        reset = 2'b00;
        req = 2'b00;
        r = cyc;
        issue(0, 1, 2, 32'h40, 32'hDEAD_BEEF, 0, 4'b1111, t0);
        check("dut0 accept in first cycle after reset", t0, r);
        idle(0, 2);
        issue(0, 0, 2, 32'h40, 0, 32'hDEAD_BEEF, 4'b0000, t0);
        idle(0, 3);
        issue(0, 1, 2, 32'h40, 32'h0, 0, 4'b1111, t0);
        issue(0, 1, 0, 32'h43, 32'hAA00_0000, 0, 4'b1000, t0);
        issue(0, 0, 2, 32'h40, 0, 32'hAA00_0000, 4'b0000, t0);
        issue(0, 1, 1, 32'h47, 32'hBEEF_0000, 0, 4'b1100, t0);
        issue(0, 1, 0, 32'h45, 32'h0000_7700, 0, 4'b0010, t0);
        issue(0, 0, 2, 32'h44, 0, 32'hBEEF_7711, 4'b0000, t0);
        issue(0, 1, 3, 32'h4B, 32'h0102_0304, 0, 4'b1111, t0);
        issue(0, 1, 1, 32'h4C, 32'h0000_ABCD, 0, 4'b0011, t0);
        issue(0, 0, 2, 32'h48, 0, 32'h0102_0304, 4'b0000, t0);
        issue(0, 0, 2, 32'h4C, 0, 32'hC0DE_ABCD, 4'b0000, t0);
        idle(0, 4);
        issue(0, 0, 2, 32'h0, 0, 32'hC0DE_0000, 4'b0000, t0);
        issue(0, 0, 2, 32'h4, 0, 32'hC0DE_0001, 4'b0000, t1);
        issue(0, 0, 2, 32'h8, 0, 32'hC0DE_0002, 4'b0000, t2);
        check("dut0 back-to-back accept 2", t1 - t0, 1);
        check("dut0 back-to-back accept 3", t2 - t1, 1);
        idle(0, 4);
        issue(0, 1, 2, 32'h80, 32'h1234_5678, 0, 4'b1111, t0);
        issue(0, 0, 2, 32'h80, 0, 32'h1234_5678, 4'b0000, t1);
        check("dut0 write-then-read spacing", t1 - t0, 1);
        idle(0, 4);
        issue(0, 0, 2, 32'h0, 0, 32'hC0DE_0000, 4'b0000, t0);
        issue(0, 0, 2, 32'h4, 0, 32'hC0DE_0001, 4'b0000, t1);
        reset[0] = 1'b1;
        sb[0].delete();
        repeat (2) begin
            @(negedge clk);
            check("dut0 data_ok during reset", data_ok[0], 0);
            check("dut0 addr_ok during reset", addr_ok[0], 0);
        end
        @(posedge clk);
        #1;
        reset[0] = 1'b0;
        r = cyc;
        issue(0, 0, 2, 32'h8, 0, 32'hC0DE_0002, 4'b0000, t0);
        check("dut0 accept right after mid-op reset", t0, r);
        idle(0, 1);
        for (int i = 0; i < 6; i++) issue(1, 0, 2, 32'(4 * i), 0, 32'hC0DE_0000 + 32'(i), 4'b0000, bp[i]);
        idle(1, 1);
        for (int i = 0; i < 6; i++) check($sformatf("dut1 backpressure accept %0d", i), bp[i] - bp[0], rel[i]);
        n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain timeout: got %0d/%0d pending, required 0/0", sb[0].size(), sb[1].size());
        end
        repeat (6) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
